mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported memory between an instruction-fetch
//            port and a data port. Each access holds the memory for
//            ACC_CYCLES cycles. Misaligned (odd) addresses are rejected with
//            an err pulse. Define ARB_ROUND_ROBIN_EN for round-robin
//            tie-breaking; otherwise the data port wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(ACC_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic        r_gnt_dm;
    logic        r_if_done;
    logic        r_dm_done;
    logic        r_err;
    logic [15:0] r_if_rdata;
    logic [15:0] r_dm_rdata;

    logic        w_if_q;
    logic        w_dm_q;
    logic        w_any;
    logic        w_gnt_dm;
    logic [15:0] w_sel_addr;
    logic        w_misalign;
    logic        w_start;
    logic        w_reject;
    logic        w_finish;
    logic        w_busy;

    // A port whose done is high this cycle is still holding req; mask it so
    // the same request is not granted twice.
    assign w_if_q = if_req & ~r_if_done;
    assign w_dm_q = dm_req & ~r_dm_done;
    assign w_any  = w_if_q | w_dm_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dm;

    assign w_gnt_dm = w_dm_q & (~w_if_q | ~r_last_dm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dm <= 1'b0;
        end else if (w_start | w_reject) begin
            r_last_dm <= w_gnt_dm;
        end
    end
`else
    assign w_gnt_dm = w_dm_q;
`endif

    assign w_sel_addr = w_gnt_dm ? dm_addr : if_addr;
    assign w_misalign = w_sel_addr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_reject     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_misalign) begin
                        w_reject = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_wr       <= 1'b0;
            r_gnt_dm   <= 1'b0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= 16'h0000;
            r_dm_rdata <= 16'h0000;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_err     <= 1'b0;
            if (w_start) begin
                r_addr   <= w_sel_addr;
                r_wr     <= w_gnt_dm & dm_wr;
                r_wdata  <= w_gnt_dm ? dm_wdata : 16'h0000;
                r_gnt_dm <= w_gnt_dm;
                r_cnt    <= c_cnt_load;
            end
            if (w_reject) begin
                r_if_done <= ~w_gnt_dm;
                r_dm_done <= w_gnt_dm;
                r_err     <= 1'b1;
            end
            if (r_state == S_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish) begin
                r_if_done <= ~r_gnt_dm;
                r_dm_done <= r_gnt_dm;
                if (!r_gnt_dm) begin
                    r_if_rdata <= mem_rdata;
                end else if (!r_wr) begin
                    r_dm_rdata <= mem_rdata;
                end
            end
        end
    end

    // Memory drive is qualified by state so IDLE (and reset) force zeros.
    assign w_busy    = (r_state == S_BUSY);
    assign busy      = w_busy;
    assign mem_en    = w_busy;
    assign mem_wr    = w_busy & r_wr;
    assign mem_addr  = w_busy ? r_addr : 16'h0000;
    assign mem_wdata = w_busy ? r_wdata : 16'h0000;

    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign if_done  = r_if_done;
    assign dm_done  = r_dm_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with ACC_CYCLES = 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_acc = 2;
    localparam logic [15:0] c_key = 16'hA5B5;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        err;

    typedef struct {
        bit          is_dm;
        bit          err;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_if_rdata = 16'h0000;
    logic [15:0] exp_dm_rdata = 16'h0000;

    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of the address.
    assign mem_rdata = mem_en ? (mem_addr ^ c_key) : 16'h0000;

    mem_port_arbiter #(.ACC_CYCLES(c_acc)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    // Waits for the next done pulse, recording memory activity on the way.
    task automatic wait_done(output bit got_if, output bit got_dm, output bit got_err,
                             output int lat, output int en_cnt, output logic [15:0] a,
                             output logic w, output logic [15:0] wd);
        got_if = 0; got_dm = 0; got_err = 0; lat = -1; en_cnt = 0;
        a = 16'h0000; w = 1'b0; wd = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++; a = mem_addr; w = mem_wr; wd = mem_wdata;
            end
            if (if_done || dm_done) begin
                got_if = if_done; got_dm = dm_done; got_err = err; lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, busy, err, if_done, dm_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got en/wr/busy/err/ifd/dmd=%b, required 000000",
                     {mem_en, mem_wr, busy, err, if_done, dm_done});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h ifr=%h dmr=%h, required all 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_read();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        if_req = 1; if_addr = 16'h0010;
        exp_if_rdata = 16'h0010 ^ c_key;
        sb.push_back('{is_dm: 0, err: 0, rdata: exp_if_rdata});
        wait_done(gi, gd, ge, lat, en, a, w, wd);
        if_req = 0;
        e = sb.pop_front();
        checks++;
        if (gi !== !e.is_dm || gd !== e.is_dm || ge !== e.err || if_rdata !== e.rdata) begin
            errors++;
            $display("FAIL fetch_sb: got ifd=%0b dmd=%0b err=%0b ifr=%h, required dm=%0b err=%0b ifr=%h",
                     gi, gd, ge, if_rdata, e.is_dm, e.err, e.rdata);
        end
        checks++;
        if (lat !== c_acc + 1 || en !== c_acc) begin
            errors++;
            $display("FAIL fetch_timing: got lat=%0d en_cycles=%0d, required lat=%0d en_cycles=%0d",
                     lat, en, c_acc + 1, c_acc);
        end
        checks++;
        if (a !== 16'h0010 || w !== 1'b0) begin
            errors++;
            $display("FAIL fetch_mem: got addr=%h wr=%b, required addr=0010 wr=0", a, w);
        end
        @(negedge clk);
        checks++;
        if (if_done !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: got if_done=%b mem_en=%b after pulse, required 0 0", if_done, mem_en);
        end
    endtask

    task automatic test_dm_read();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0040; dm_wdata = 16'hFFFF;
        exp_dm_rdata = 16'h0040 ^ c_key;
        sb.push_back('{is_dm: 1, err: 0, rdata: exp_dm_rdata});
        wait_done(gi, gd, ge, lat, en, a, w, wd);
        dm_req = 0;
        e = sb.pop_front();
        checks++;
        if (gi !== !e.is_dm || gd !== e.is_dm || ge !== e.err || dm_rdata !== e.rdata ||
            if_rdata !== exp_if_rdata) begin
            errors++;
            $display("FAIL dm_read_sb: got dmd=%0b err=%0b dmr=%h ifr=%h, required dmr=%h ifr=%h",
                     gd, ge, dm_rdata, if_rdata, e.rdata, exp_if_rdata);
        end
        checks++;
        if (lat !== c_acc + 1 || en !== c_acc || a !== 16'h0040 || w !== 1'b0) begin
            errors++;
            $display("FAIL dm_read_mem: got lat=%0d en=%0d addr=%h wr=%b, required 3 2 0040 0",
                     lat, en, a, w);
        end
        @(negedge clk);
    endtask

    task automatic test_dm_write();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        dm_req = 1; dm_wr = 1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
        sb.push_back('{is_dm: 1, err: 0, rdata: exp_dm_rdata});
        wait_done(gi, gd, ge, lat, en, a, w, wd);
        dm_req = 0; dm_wr = 0;
        e = sb.pop_front();
        checks++;
        if (gd !== e.is_dm || gi !== !e.is_dm || ge !== e.err || dm_rdata !== e.rdata) begin
            errors++;
            $display("FAIL dm_write_sb: got dmd=%0b err=%0b dmr=%h, required dmr=%h unchanged",
                     gd, ge, dm_rdata, e.rdata);
        end
        checks++;
        if (lat !== c_acc + 1 || en !== c_acc || a !== 16'h0020 || w !== 1'b1 || wd !== 16'h1234) begin
            errors++;
            $display("FAIL dm_write_mem: got lat=%0d en=%0d addr=%h wr=%b wdata=%h, required 3 2 0020 1 1234",
                     lat, en, a, w, wd);
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0021;
        sb.push_back('{is_dm: 1, err: 1, rdata: exp_dm_rdata});
        wait_done(gi, gd, ge, lat, en, a, w, wd);
        dm_req = 0;
        e = sb.pop_front();
        checks++;
        if (gd !== e.is_dm || gi !== !e.is_dm || ge !== e.err || dm_rdata !== e.rdata ||
            lat !== 1 || en !== 0) begin
            errors++;
            $display("FAIL dm_misalign: got dmd=%0b err=%0b dmr=%h lat=%0d en=%0d, required 1 1 %h 1 0",
                     gd, ge, dm_rdata, lat, en, e.rdata);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || dm_done !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got err=%b dm_done=%b mem_en=%b, required 0 0 0",
                     err, dm_done, mem_en);
        end
        if_req = 1; if_addr = 16'h0013;
        sb.push_back('{is_dm: 0, err: 1, rdata: exp_if_rdata});
        wait_done(gi, gd, ge, lat, en, a, w, wd);
        if_req = 0;
        e = sb.pop_front();
        checks++;
        if (gi !== !e.is_dm || gd !== e.is_dm || ge !== e.err || if_rdata !== e.rdata ||
            lat !== 1 || en !== 0) begin
            errors++;
            $display("FAIL if_misalign: got ifd=%0b err=%0b ifr=%h lat=%0d en=%0d, required 1 1 %h 1 0",
                     gi, ge, if_rdata, lat, en, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        if_req = 1; if_addr = 16'h0100;
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0200;
        exp_dm_rdata = 16'h0200 ^ c_key;
        exp_if_rdata = 16'h0100 ^ c_key;
        sb.push_back('{is_dm: 1, err: 0, rdata: exp_dm_rdata});
        sb.push_back('{is_dm: 0, err: 0, rdata: exp_if_rdata});
        for (int k = 0; k < 2; k++) begin
            wait_done(gi, gd, ge, lat, en, a, w, wd);
            if (gd) dm_req = 0;
            if (gi) if_req = 0;
            e = sb.pop_front();
            checks++;
            if (gd !== e.is_dm || gi !== !e.is_dm || ge !== e.err || lat !== c_acc + 1 ||
                (e.is_dm ? dm_rdata : if_rdata) !== e.rdata) begin
                errors++;
                $display("FAIL tie_%0d: got ifd=%0b dmd=%0b lat=%0d ifr=%h dmr=%h, required dm=%0b lat=3 rdata=%h",
                         k, gi, gd, lat, if_rdata, dm_rdata, e.is_dm, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit gi, gd, ge; int lat, en; logic [15:0] a, wd; logic w; exp_t e;
        if_req = 1; if_addr = 16'h0300;
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0400;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{is_dm: 1, err: 0, rdata: 16'h0400 ^ c_key});
            else            sb.push_back('{is_dm: 0, err: 0, rdata: 16'h0300 ^ c_key});
        end
        for (int k = 0; k < 4; k++) begin
            wait_done(gi, gd, ge, lat, en, a, w, wd);
            e = sb.pop_front();
            checks++;
            if (gd !== e.is_dm || gi !== !e.is_dm || lat !== c_acc + 1 ||
                (e.is_dm ? dm_rdata : if_rdata) !== e.rdata) begin
                errors++;
                $display("FAIL b2b_%0d: got ifd=%0b dmd=%0b lat=%0d ifr=%h dmr=%h, required dm=%0b lat=3 rdata=%h",
                         k, gi, gd, lat, if_rdata, dm_rdata, e.is_dm, e.rdata);
            end
        end
        if_req = 0; dm_req = 0;
        exp_if_rdata = 16'h0300 ^ c_key;
        exp_dm_rdata = 16'h0400 ^ c_key;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int seen_done;
        if_req = 1; if_addr = 16'h0010;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got busy=%b mem_en=%b before reset, required 1 1", busy, mem_en);
        end
        rst = 1'b1;
        if_req = 0;
        #1;
        checks++;
        if ({mem_en, mem_wr, busy, err, if_done, dm_done} !== 6'b0 ||
            {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_zero: got ctrl=%b addr=%h ifr=%h dmr=%h, required all 0",
                     {mem_en, mem_wr, busy, err, if_done, dm_done}, mem_addr, if_rdata, dm_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_done || mem_en) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || if_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_after: got done/en cycles=%0d ifr=%h, required 0 0000", seen_done, if_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_dm_read();
        test_dm_write();
        test_misaligned();
        test_tie();
        test_back_to_back();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
